// File: rtl/popcount_frame_accumulator_pkg.sv
// Purpose : shared constants for the popcount frame accumulator slice.
//           Provides the default word-width exponent, the FSM state
//           encodings and a helper for the width of a saturating sum.
// Ports   : none (package).
package popcount_frame_accumulator_pkg;

  // Words are 2**DEFAULT_LOG_BIT_WIDTH bits wide unless overridden.
  localparam int DEFAULT_LOG_BIT_WIDTH = 5;

  // Frame FSM encodings.
  localparam logic [0:0] ST_ACC  = 1'b0;  // collecting words of a frame
  localparam logic [0:0] ST_HOLD = 1'b1;  // result presented, waiting for out_ready

  // A saturating add of a w-bit register needs one extra carry bit.
  function automatic int sat_sum_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/popcount_frame_accumulator_ones_counter.sv
// Purpose : combinational population count of one word.
// Ports   : word_in [2**log_bit_width-1:0]  word to count
//           count   [2**log_bit_width-1:0]  number of set bits (zero-extended)
module ones_counter
  import popcount_frame_accumulator_pkg::*;
#(
  parameter int log_bit_width = DEFAULT_LOG_BIT_WIDTH
) (
  input  logic [(2**log_bit_width)-1:0] word_in,
  output logic [(2**log_bit_width)-1:0] count
);

  localparam int W = 2**log_bit_width;

  // Sum the individual bits of the word.
  always_comb begin
    count = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      count = count + {{(W-1){1'b0}}, word_in[i]};
    end
  end

endmodule

// File: rtl/popcount_frame_accumulator.sv
// Purpose : accepts words over valid/ready, popcounts each one, sums the
//           counts over a frame closed by in_last and presents the frame
//           total, word count and overflow flag on a valid/ready output.
// Ports   : clk, rst (async, active-high)
//           in_valid / in_ready / word_in / in_last   input word stream
//           out_valid / out_ready                     result handshake
//           frame_count [ACC_WIDTH-1:0]   saturating sum of ones in frame
//           frame_words [WCNT_WIDTH-1:0]  saturating number of words in frame
//           overflow                      either total saturated in frame
// Note    : LOG_BIT_WIDTH must be >= 2 and ACC_WIDTH >= LOG_BIT_WIDTH+1.
module popcount_frame_accumulator
  import popcount_frame_accumulator_pkg::*;
#(
  parameter int LOG_BIT_WIDTH = DEFAULT_LOG_BIT_WIDTH,
  parameter int ACC_WIDTH     = 10,
  parameter int WCNT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [(2**LOG_BIT_WIDTH)-1:0] word_in,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          frame_count,
  output logic [WCNT_WIDTH-1:0]         frame_words,
  output logic                          overflow
);

  localparam int WORD_W     = 2**LOG_BIT_WIDTH;
  localparam int CNT_W      = LOG_BIT_WIDTH + 1;
  localparam int ACC_SUM_W  = sat_sum_width(ACC_WIDTH);
  localparam int WCNT_SUM_W = sat_sum_width(WCNT_WIDTH);

  logic [0:0]            state_r;
  logic                  s1_valid_r;
  logic                  s1_last_r;
  logic [CNT_W-1:0]      s1_cnt_r;
  logic [ACC_WIDTH-1:0]  acc_r;
  logic [WCNT_WIDTH-1:0] wcnt_r;
  logic                  ovf_r;

  logic [WORD_W-1:0]     ones_full_s;
  logic [CNT_W-1:0]      ones_cnt_s;
  logic                  accept_s;
  logic [ACC_SUM_W-1:0]  acc_sum_s;
  logic [ACC_WIDTH-1:0]  acc_next_s;
  logic                  acc_sat_s;
  logic [WCNT_SUM_W-1:0] wcnt_sum_s;
  logic [WCNT_WIDTH-1:0] wcnt_next_s;
  logic                  wcnt_sat_s;

  ones_counter #(.log_bit_width(LOG_BIT_WIDTH)) u_ones_counter (
    .word_in (word_in),
    .count   (ones_full_s)
  );

  // A pending last word in stage 1 blocks intake so frames never overlap.
  assign in_ready = (state_r == ST_ACC) && !(s1_valid_r && s1_last_r);
  assign accept_s = in_valid && in_ready;

  // Only the low bits of the counter are meaningful; clamp rather than wrap
  // if the upper bits ever report something.
  always_comb begin
    if (|ones_full_s[WORD_W-1:CNT_W]) begin
      ones_cnt_s = {CNT_W{1'b1}};
    end else begin
      ones_cnt_s = ones_full_s[CNT_W-1:0];
    end
  end

  // Saturating next values for the running total and word counter.
  always_comb begin
    acc_sum_s  = {1'b0, acc_r} + {{(ACC_SUM_W-CNT_W){1'b0}}, s1_cnt_r};
    wcnt_sum_s = {1'b0, wcnt_r} + {{WCNT_WIDTH{1'b0}}, 1'b1};
    acc_sat_s  = acc_sum_s[ACC_WIDTH];
    wcnt_sat_s = wcnt_sum_s[WCNT_WIDTH];
    if (acc_sat_s) begin
      acc_next_s = {ACC_WIDTH{1'b1}};
    end else begin
      acc_next_s = acc_sum_s[ACC_WIDTH-1:0];
    end
    if (wcnt_sat_s) begin
      wcnt_next_s = {WCNT_WIDTH{1'b1}};
    end else begin
      wcnt_next_s = wcnt_sum_s[WCNT_WIDTH-1:0];
    end
  end

  // Stage 1: capture popcount and last flag of each accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_last_r  <= in_last;
      s1_cnt_r   <= ones_cnt_s;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: accumulate, close frames into the output registers, run the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_ACC;
      acc_r       <= {ACC_WIDTH{1'b0}};
      wcnt_r      <= {WCNT_WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      out_valid   <= 1'b0;
      frame_count <= {ACC_WIDTH{1'b0}};
      frame_words <= {WCNT_WIDTH{1'b0}};
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (s1_valid_r && s1_last_r) begin
            frame_count <= acc_next_s;
            frame_words <= wcnt_next_s;
            overflow    <= ovf_r | acc_sat_s | wcnt_sat_s;
            out_valid   <= 1'b1;
            acc_r       <= {ACC_WIDTH{1'b0}};
            wcnt_r      <= {WCNT_WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            state_r     <= ST_HOLD;
          end else if (s1_valid_r) begin
            acc_r  <= acc_next_s;
            wcnt_r <= wcnt_next_s;
            ovf_r  <= ovf_r | acc_sat_s | wcnt_sat_s;
          end else begin
            acc_r <= acc_r;
          end
        end
        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_ACC;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Purpose : scoreboard bench for popcount_frame_accumulator. Instance a uses
//           default widths, instance b uses ACC_WIDTH=6 for saturation.
//           Expected frame results are queued when a frame is sent and popped
//           by per-instance monitors whenever a result handshake happens.
module tb_popcount_frame_accumulator;

  typedef struct packed {
    logic [31:0] count;
    logic [31:0] words;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a, overflow_a;
  logic [31:0] word_in_a;
  logic [9:0]  frame_count_a;
  logic [7:0]  frame_words_a;

  logic        in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, overflow_b;
  logic [31:0] word_in_b;
  logic [5:0]  frame_count_b;
  logic [7:0]  frame_words_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_vec = 0;
  int   n_err = 0;

  popcount_frame_accumulator #(.LOG_BIT_WIDTH(5), .ACC_WIDTH(10), .WCNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .word_in(word_in_a), .in_last(in_last_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .frame_count(frame_count_a),
    .frame_words(frame_words_a), .overflow(overflow_a)
  );

  popcount_frame_accumulator #(.LOG_BIT_WIDTH(5), .ACC_WIDTH(6), .WCNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .word_in(word_in_b), .in_last(in_last_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .frame_count(frame_count_b),
    .frame_words(frame_words_b), .overflow(overflow_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for instance a: compare every result that is handed off.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result_a: got count %0d expected no result", frame_count_a);
      end else begin
        e_a = q_a.pop_front();
        check("count_a", {22'd0, frame_count_a}, e_a.count);
        check("words_a", {24'd0, frame_words_a}, e_a.words);
        check("ovf_a",   {31'd0, overflow_a},    {31'd0, e_a.ovf});
      end
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result_b: got count %0d expected no result", frame_count_b);
      end else begin
        e_b = q_b.pop_front();
        check("count_b", {26'd0, frame_count_b}, e_b.count);
        check("words_b", {24'd0, frame_words_b}, e_b.words);
        check("ovf_b",   {31'd0, overflow_b},    {31'd0, e_b.ovf});
      end
    end
  end

  // Offer one word until accepted; returns 1 time unit after the accept edge.
  task automatic send(input int sel, input logic [31:0] w, input logic last);
    int guard;
    guard = 0;
    if (sel == 0) begin
      in_valid_a = 1'b1; word_in_a = w; in_last_a = last;
    end else begin
      in_valid_b = 1'b1; word_in_b = w; in_last_b = last;
    end
    @(negedge clk);
    while (!((sel == 0) ? in_ready_a : in_ready_b) && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      in_valid_a = 1'b0; word_in_a = 32'd0; in_last_a = 1'b0;
    end else begin
      in_valid_b = 1'b0; word_in_b = 32'd0; in_last_b = 1'b0;
    end
  endtask

  // Wait (bounded) for out_valid; returns 1 time unit after the next edge.
  task automatic wait_out(input int sel);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!((sel == 0) ? out_valid_a : out_valid_b) && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL out_timeout: out_valid got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid_a = 1'b0; word_in_a = 32'd0; in_last_a = 1'b0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; word_in_b = 32'd0; in_last_b = 1'b0; out_ready_b = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // 1: reset pulse while idle
    rst = 1'b1;
    #2;
    check("rst_out_valid",   {31'd0, out_valid_a},   32'd0);
    check("rst_frame_count", {22'd0, frame_count_a}, 32'd0);
    check("rst_frame_words", {24'd0, frame_words_a}, 32'd0);
    check("rst_overflow",    {31'd0, overflow_a},    32'd0);
    check("rst_out_valid_b", {31'd0, out_valid_b},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready_a", {31'd0, in_ready_a}, 32'd1);
    check("rst_in_ready_b", {31'd0, in_ready_b}, 32'd1);
    idle(1);

    // 2: single all-ones word, check latency
    q_a.push_back('{count: 32'd32, words: 32'd1, ovf: 1'b0});
    send(0, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    check("lat_after_k",  {31'd0, out_valid_a}, 32'd0);
    @(negedge clk);
    check("lat_after_k1", {31'd0, out_valid_a}, 32'd1);
    idle(1);

    // 3: three-word frame with gaps
    q_a.push_back('{count: 32'd6, words: 32'd3, ovf: 1'b0});
    send(0, 32'h0000_000F, 1'b0);
    idle(2);
    send(0, 32'h8000_0001, 1'b0);
    idle(3);
    send(0, 32'h0000_0000, 1'b1);
    wait_out(0);
    idle(1);

    // 4: back-pressure on the result; offered words must be ignored
    out_ready_a = 1'b0;
    q_a.push_back('{count: 32'd8, words: 32'd1, ovf: 1'b0});
    send(0, 32'h0000_00FF, 1'b1);
    wait_out(0);
    in_valid_a = 1'b1; word_in_a = 32'hFFFF_FFFF; in_last_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid",   {31'd0, out_valid_a},   32'd1);
      check("hold_frame_count", {22'd0, frame_count_a}, 32'd8);
      check("hold_frame_words", {24'd0, frame_words_a}, 32'd1);
      check("hold_in_ready",    {31'd0, in_ready_a},    32'd0);
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0; word_in_a = 32'd0; in_last_a = 1'b0;
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("release_in_ready",  {31'd0, in_ready_a},  32'd1);
    idle(2);

    // 5: saturation on the narrow instance, then overflow clears
    q_b.push_back('{count: 32'd63, words: 32'd3, ovf: 1'b1});
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b1);
    wait_out(1);
    q_b.push_back('{count: 32'd1, words: 32'd1, ovf: 1'b0});
    send(1, 32'h0000_0001, 1'b1);
    wait_out(1);
    idle(2);

    // 6: asynchronous reset mid-frame discards it
    send(0, 32'h0000_00FF, 1'b0);
    send(0, 32'h0000_FF00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid",   {31'd0, out_valid_a},   32'd0);
    check("midrst_frame_count", {22'd0, frame_count_a}, 32'd0);
    check("midrst_frame_words", {24'd0, frame_words_a}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_result", {31'd0, out_valid_a}, 32'd0);
    end
    idle(1);
    q_a.push_back('{count: 32'd2, words: 32'd1, ovf: 1'b0});
    send(0, 32'h0000_0003, 1'b1);
    wait_out(0);
    idle(3);

    check("queue_a_drained", q_a.size(), 32'd0);
    check("queue_b_drained", q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
